// File: rtl/codeword_arbiter_pkg.sv
// Types shared by the codeword arbiter and its round-robin grant helper.
package codeword_arbiter_pkg;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_BUSY = 1'b1;

    typedef logic [0:0] src_idx_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       sop;
        logic       is_parity;
    } beat_t;

endpackage

// File: rtl/interleaver_pkg.sv
// Shared constants of the byte interleaver datapath.
package interleaver_pkg;

    localparam int CODEWORD_BYTES = 16;

endpackage

// File: rtl/codeword_arbiter_rr_grant2.sv
// Two-way round-robin grant: on contention the source not served last wins.
module rr_grant2
    import codeword_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  src_idx_t   last_served,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] && (!req[1] || last_served == 1'b1);
    assign gnt[1] = req[1] && (!req[0] || last_served == 1'b0);

endmodule

// File: rtl/codeword_arbiter.sv
// Merges two codeword byte streams into one, holding the grant for a whole
// codeword and flagging stray bytes and wrong-length codewords.
module codeword_arbiter
    import codeword_arbiter_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int CW_BYTES = interleaver_pkg::CODEWORD_BYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s0_axis_valid,
    output logic       s0_axis_ready,
    input  logic [7:0] s0_axis_data,
    input  logic       s0_axis_last,
    input  logic       s0_axis_sop,
    input  logic       s0_axis_is_parity,
    input  logic       s1_axis_valid,
    output logic       s1_axis_ready,
    input  logic [7:0] s1_axis_data,
    input  logic       s1_axis_last,
    input  logic       s1_axis_sop,
    input  logic       s1_axis_is_parity,
    output logic       m_axis_valid,
    input  logic       m_axis_ready,
    output logic [7:0] m_axis_data,
    output logic       m_axis_last,
    output logic       m_axis_sop,
    output logic       m_axis_is_parity,
    output logic       m_axis_src,
    output logic       desync_err,
    output logic       len_err
);

    localparam logic [7:0] LAST_IDX = 8'(CW_BYTES - 1);

    arb_state_t         state_q;
    src_idx_t           grant_q;
    src_idx_t           last_q;
    logic [7:0]         count_q;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt;
    logic [NUM_SRC-1:0] drain;
    beat_t              beat0;
    beat_t              beat1;
    beat_t              sel;
    logic               sel_valid;
    logic               busy;
    logic               hs;
    logic               at_last_idx;
    logic               cw_end;
    logic               len_bad;

    assign busy  = (state_q == ST_BUSY);
    assign beat0 = '{data: s0_axis_data, last: s0_axis_last, sop: s0_axis_sop, is_parity: s0_axis_is_parity};
    assign beat1 = '{data: s1_axis_data, last: s1_axis_last, sop: s1_axis_sop, is_parity: s1_axis_is_parity};

    assign req[0] = s0_axis_valid && s0_axis_sop;
    assign req[1] = s1_axis_valid && s1_axis_sop;

    // NOTE: state is already IDLE while rst is high, so draining must also be
    // gated by rst itself or ready would rise during reset.
    assign drain[0] = !busy && !rst && s0_axis_valid && !s0_axis_sop;
    assign drain[1] = !busy && !rst && s1_axis_valid && !s1_axis_sop && !drain[0];

    rr_grant2 u_rr_grant2 (
        .req         (req),
        .last_served (last_q),
        .gnt         (gnt)
    );

    // Zero-latency mirror of the granted source while a codeword is in flight.
    assign sel       = (grant_q == 1'b1) ? beat1 : beat0;
    assign sel_valid = (grant_q == 1'b1) ? s1_axis_valid : s0_axis_valid;

    assign m_axis_valid     = busy && sel_valid;
    assign m_axis_data      = busy ? sel.data : 8'h00;
    assign m_axis_last      = busy && sel.last;
    assign m_axis_sop       = busy && sel.sop;
    assign m_axis_is_parity = busy && sel.is_parity;
    assign m_axis_src       = busy ? grant_q : 1'b0;

    assign s0_axis_ready = busy ? (grant_q == 1'b0 && m_axis_ready) : drain[0];
    assign s1_axis_ready = busy ? (grant_q == 1'b1 && m_axis_ready) : drain[1];

    assign hs          = m_axis_valid && m_axis_ready;
    assign at_last_idx = (count_q == LAST_IDX);
    assign cw_end      = hs && (sel.last || at_last_idx);
    assign len_bad     = hs && (sel.last != at_last_idx);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            count_q    <= 8'd0;
            desync_err <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            desync_err <= |drain;
            len_err    <= len_bad;
            if (!busy) begin
                if (|req) begin
                    state_q <= ST_BUSY;
                    grant_q <= (gnt == 2'b10) ? 1'b1 : 1'b0;
                    count_q <= 8'd0;
                end
            end else if (hs) begin
                count_q <= count_q + 8'd1;
                if (cw_end) begin
                    state_q <= ST_IDLE;
                    last_q  <= grant_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_codeword_arbiter.sv
// Self-checking bench for codeword_arbiter: IDLE vector table, directed
// ordering/error sequences and a randomized gap run against a scoreboard.
module tb_codeword_arbiter;

    localparam int N = interleaver_pkg::CODEWORD_BYTES;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       last;
        logic       par;
        logic       drop;
    } item_t;

    typedef struct {
        logic v0, p0, v1, p1, r0, r1;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       s_valid [2];
    logic [7:0] s_data  [2];
    logic       s_last  [2];
    logic       s_sop   [2];
    logic       s_par   [2];
    logic       s0_ready, s1_ready;
    logic       m_axis_valid, m_axis_ready;
    logic [7:0] m_axis_data;
    logic       m_axis_last, m_axis_sop, m_axis_is_parity, m_axis_src;
    logic       desync_err, len_err;

    item_t stim0[$], stim1[$], exp0[$], exp1[$];
    int    order_q[$], exp_order[$];
    int    n_checks, n_errors;
    int    n_desync, n_len, exp_desync, exp_len;
    int    gap_pct, ready_gap;
    logic  hold_ready;
    logic [6:0] seq [2];
    logic  in_cw;
    int    cw_src, cw_pos;
    vec_t  vecs [9];

    codeword_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .s0_axis_valid     (s_valid[0]),
        .s0_axis_ready     (s0_ready),
        .s0_axis_data      (s_data[0]),
        .s0_axis_last      (s_last[0]),
        .s0_axis_sop       (s_sop[0]),
        .s0_axis_is_parity (s_par[0]),
        .s1_axis_valid     (s_valid[1]),
        .s1_axis_ready     (s1_ready),
        .s1_axis_data      (s_data[1]),
        .s1_axis_last      (s_last[1]),
        .s1_axis_sop       (s_sop[1]),
        .s1_axis_is_parity (s_par[1]),
        .m_axis_valid      (m_axis_valid),
        .m_axis_ready      (m_axis_ready),
        .m_axis_data       (m_axis_data),
        .m_axis_last       (m_axis_last),
        .m_axis_sop        (m_axis_sop),
        .m_axis_is_parity  (m_axis_is_parity),
        .m_axis_src        (m_axis_src),
        .desync_err        (desync_err),
        .len_err           (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_item(input int src, input item_t it);
        if (src == 0) begin
            stim0.push_back(it);
            if (!it.drop) exp0.push_back(it);
        end else begin
            stim1.push_back(it);
            if (!it.drop) exp1.push_back(it);
        end
    endtask

    // Codeword starting with sop; bytes past the point where the arbiter
    // closes the codeword arrive while idle and are expected to be drained.
    task automatic add_cw(input int src, input int len, input int last_idx, input int mid_sop);
        item_t it;
        int    endi;
        endi = ((last_idx < N - 1) ? last_idx : N - 1) + 1;
        if (last_idx != N - 1) exp_len++;
        exp_desync += len - endi;
        for (int i = 0; i < len; i++) begin
            it.data = {src[0], seq[src]};
            seq[src] = seq[src] + 7'd1;
            it.sop  = (i == 0) || (i == mid_sop);
            it.last = (i == last_idx);
            it.par  = (i >= N - 4);
            it.drop = (i >= endi);
            push_item(src, it);
        end
    endtask

    task automatic add_raw(input int src, input int n);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.data = {src[0], seq[src]};
            seq[src] = seq[src] + 7'd1;
            it.sop  = 1'b0;
            it.last = 1'b0;
            it.par  = 1'b0;
            it.drop = 1'b1;
            push_item(src, it);
        end
        exp_desync += n;
    endtask

    task automatic update_src(input int i, input logic hs);
        item_t it;
        logic  have;
        if (hs) begin
            if (i == 0) void'(stim0.pop_front());
            else        void'(stim1.pop_front());
            s_valid[i] = 1'b0;
        end
        have = (i == 0) ? (stim0.size() > 0) : (stim1.size() > 0);
        if (!s_valid[i] && have && (int'($urandom_range(99)) >= gap_pct)) begin
            if (i == 0) it = stim0[0];
            else        it = stim1[0];
            s_valid[i] = 1'b1;
            s_data[i]  = it.data;
            s_sop[i]   = it.sop;
            s_last[i]  = it.last;
            s_par[i]   = it.par;
        end
    endtask

    task automatic mon_byte();
        item_t e;
        int    src;
        src = int'(m_axis_src);
        if ((src == 0 && exp0.size() == 0) || (src == 1 && exp1.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte src=%0d data=%0h exp=none", src, m_axis_data);
        end else begin
            if (src == 0) e = exp0.pop_front();
            else          e = exp1.pop_front();
            check($sformatf("byte_src%0d", src),
                  {21'd0, m_axis_data, m_axis_sop, m_axis_last, m_axis_is_parity},
                  {21'd0, e.data, e.sop, e.last, e.par});
        end
        if (!in_cw) begin
            order_q.push_back(src);
            cw_src = src;
            cw_pos = 0;
            in_cw  = 1'b1;
        end else begin
            check("no_interleave", src, cw_src);
        end
        cw_pos++;
        if (m_axis_last || cw_pos == N) in_cw = 1'b0;
    endtask

    // One clock: sample at the falling edge, drive just after the rising edge.
    task automatic step();
        logic hs0, hs1;
        @(negedge clk);
        hs0 = s_valid[0] && s0_ready;
        hs1 = s_valid[1] && s1_ready;
        if (m_axis_valid && m_axis_ready) mon_byte();
        if (desync_err) n_desync++;
        if (len_err)    n_len++;
        @(posedge clk);
        #1;
        update_src(0, hs0);
        update_src(1, hs1);
        m_axis_ready = (int'($urandom_range(99)) >= ready_gap) && !hold_ready;
    endtask

    task automatic begin_test();
        order_q.delete();
        n_desync   = 0;
        n_len      = 0;
        exp_desync = 0;
        exp_len    = 0;
        in_cw      = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while ((stim0.size() + stim1.size() + exp0.size() + exp1.size()) > 0 && c < budget) begin
            step();
            c++;
        end
        check($sformatf("%s_drained", name), stim0.size() + stim1.size() + exp0.size() + exp1.size(), 0);
        repeat (3) step();
        check($sformatf("%s_desync_cnt", name), n_desync, exp_desync);
        check($sformatf("%s_len_cnt", name), n_len, exp_len);
    endtask

    task automatic check_order(input string name);
        check($sformatf("%s_order_len", name), order_q.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < order_q.size(); i++)
            check($sformatf("%s_order%0d", name, i), order_q[i], exp_order[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stim0.delete(); stim1.delete(); exp0.delete(); exp1.delete();
        m_axis_ready = 1'b0;
        @(negedge clk);
        s_valid[0] = 1'b1; s_sop[0] = 1'b0;
        s_valid[1] = 1'b1; s_sop[1] = 1'b1;
        m_axis_ready = 1'b1;
        #1;
        check("rst_s0_ready", s0_ready, 0);
        check("rst_s1_ready", s1_ready, 0);
        check("rst_m_valid", m_axis_valid, 0);
        check("rst_m_src", m_axis_src, 0);
        check("rst_desync", desync_err, 0);
        check("rst_len", len_err, 0);
        @(negedge clk);
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        gap_pct = 0; ready_gap = 0; hold_ready = 1'b0;
        seq[0] = '0; seq[1] = '0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_data[i] = '0; s_last[i] = 1'b0;
            s_sop[i] = 1'b0; s_par[i] = 1'b0;
        end
        m_axis_ready = 1'b0;
        rst = 1'b1;
        begin_test();

        //             v0 p0 v1 p1 r0 r1
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        do_reset();

        // IDLE ready/valid table; valids are removed before each rising edge.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            s_valid[0] = vecs[k].v0; s_sop[0] = vecs[k].p0;
            s_valid[1] = vecs[k].v1; s_sop[1] = vecs[k].p1;
            m_axis_ready = 1'b1;
            #1;
            check($sformatf("idle_vec%0d_r0", k), s0_ready, vecs[k].r0);
            check($sformatf("idle_vec%0d_r1", k), s1_ready, vecs[k].r1);
            check($sformatf("idle_vec%0d_mvalid", k), m_axis_valid, 0);
            check($sformatf("idle_vec%0d_msrc", k), m_axis_src, 0);
            #1;
            s_valid[0] = 1'b0;
            s_valid[1] = 1'b0;
        end

        // Single source, full codeword.
        begin_test();
        add_cw(0, N, N - 1, -1);
        wait_drain("single", 500);
        exp_order = '{0};
        check_order("single");

        // Simultaneous sop after reset: source 0 first.
        do_reset();
        begin_test();
        add_cw(0, N, N - 1, -1);
        add_cw(1, N, N - 1, -1);
        wait_drain("contend", 500);
        exp_order = '{0, 1};
        check_order("contend");

        // Source 1 back-to-back while source 0 waits.
        begin_test();
        add_cw(1, N, N - 1, -1);
        add_cw(1, N, N - 1, -1);
        step();
        step();
        add_cw(0, N, N - 1, -1);
        wait_drain("b2b", 1000);
        exp_order = '{1, 0, 1};
        check_order("b2b");

        // Early last at byte 9, then a normal codeword.
        begin_test();
        add_cw(0, 10, 9, -1);
        add_cw(0, N, N - 1, -1);
        wait_drain("short", 1000);
        exp_order = '{0, 0};
        check_order("short");

        // Missing last: codeword closes at N bytes, the tail is drained.
        begin_test();
        add_cw(0, N + 4, N + 3, -1);
        wait_drain("long", 1000);
        exp_order = '{0};
        check_order("long");

        // Mid-codeword sop is forwarded.
        begin_test();
        add_cw(1, N, N - 1, 5);
        wait_drain("midsop", 500);
        exp_order = '{1};
        check_order("midsop");

        // Stray bytes while idle, then a proper codeword.
        begin_test();
        add_raw(1, 3);
        add_cw(1, N, N - 1, -1);
        wait_drain("desync", 500);
        exp_order = '{1};
        check_order("desync");

        // Stall: first byte must hold steady while m_axis_ready is low.
        begin_test();
        hold_ready = 1'b1;
        add_cw(0, N, N - 1, -1);
        repeat (3) step();
        check("stall_valid0", m_axis_valid, 1);
        check("stall_byte0", {m_axis_data, m_axis_sop}, {exp0[0].data, 1'b1});
        repeat (3) step();
        check("stall_valid1", m_axis_valid, 1);
        check("stall_byte1", {m_axis_data, m_axis_sop, m_axis_last}, {exp0[0].data, 1'b1, 1'b0});
        hold_ready = 1'b0;
        wait_drain("stall", 500);
        exp_order = '{0};
        check_order("stall");

        // Reset in the middle of a codeword abandons it.
        do_reset();
        begin_test();
        add_cw(0, N, N - 1, -1);
        repeat (6) step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_m_valid", m_axis_valid, 0);
        check("midrst_s0_ready", s0_ready, 0);
        check("midrst_m_src", m_axis_src, 0);
        stim0.delete();
        exp0.delete();
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        begin_test();
        step();
        step();
        rst = 1'b0;
        add_cw(1, N, N - 1, -1);
        add_cw(0, N, N - 1, -1);
        wait_drain("midrst", 1000);
        exp_order = '{0, 1};
        check_order("midrst");

        // Fair alternation with both sources always pending.
        do_reset();
        begin_test();
        ready_gap = 40;
        exp_order.delete();
        for (int k = 0; k < 6; k++) begin
            add_cw(0, N, N - 1, -1);
            add_cw(1, N, N - 1, -1);
            exp_order.push_back(0);
            exp_order.push_back(1);
        end
        wait_drain("fair", 5000);
        check_order("fair");

        // Random valid and ready gaps.
        begin_test();
        gap_pct = 30;
        ready_gap = 30;
        for (int k = 0; k < 100; k++) begin
            add_cw(0, N, N - 1, (k % 7 == 3) ? 1 + int'($urandom_range(N - 3)) : -1);
            add_cw(1, N, N - 1, (k % 5 == 2) ? 1 + int'($urandom_range(N - 3)) : -1);
        end
        wait_drain("random", 60000);
        check("random_cw_count", order_q.size(), 200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/codeword_arbiter.md
CODEWORD_ARBITER -- requirements
Module: codeword_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 2, number of upstream codeword sources; only the value 2 is supported.
REQ-002 Parameter CW_BYTES, default interleaver_pkg::CODEWORD_BYTES, bytes per codeword (N below).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 s0_axis_valid/ready/data/last/sop/is_parity  in/out/in/in/in/in  1/1/8/1/1/1  source 0 byte stream.
REQ-006 s1_axis_valid/ready/data/last/sop/is_parity  in/out/in/in/in/in  1/1/8/1/1/1  source 1 byte stream.
REQ-007 m_axis_valid/ready/data/last/sop/is_parity  out/in/out/out/out/out  1/1/8/1/1/1  merged stream to byte_interleaver input.
REQ-008 m_axis_src  out  1  index of the source owning the current output byte.
REQ-009 desync_err  out  1  one-cycle pulse: a byte was discarded while idle.
REQ-010 len_err  out  1  one-cycle pulse: a codeword ended with the wrong length.

Function
REQ-011 The arbiter SHALL have two states, IDLE and BUSY.
REQ-012 IDLE: if any source presents valid&&sop, grant it; on contention, grant the source not served most recently; go BUSY next cycle.
REQ-013 IDLE: a source with valid&&!sop SHALL be drained (ready=1) and desync_err pulsed; if both, drain lower index first.
REQ-014 IDLE: m_axis_valid=0; a sop-valid source's ready=0.
REQ-015 BUSY: m_axis_* SHALL mirror the granted source combinationally (zero latency); granted s_ready = m_axis_ready; other source ready=0.
REQ-016 BUSY: an 8-bit byte counter SHALL increment on each m_axis handshake; it clears on entering BUSY.
REQ-017 Handshake with last=1 and count==N-1: return to IDLE; record grantee as last served.
REQ-018 Handshake with last=1 and count!=N-1, or with count==N-1 and last=0: pulse len_err, return to IDLE, record grantee as last served.
REQ-019 BUSY: a sop=1 byte at count!=0 SHALL be forwarded unchanged; not an error.
REQ-020 Grant SHALL never change mid-codeword regardless of the other source's valid.
REQ-021 A valid held with m_axis_ready=0 SHALL keep data/flags stable (inherited from source) and not advance the counter.
REQ-022 m_axis_src SHALL hold the grantee index throughout BUSY; 0 in IDLE.

Reset
REQ-023 During rst: state=IDLE, counter=0, last-served=1 (source 0 wins first contention), all ready=0, m_axis_valid=0, desync_err=len_err=0.
REQ-024 Reset asserted mid-codeword SHALL abandon it immediately; no partial-codeword completion after release.

Structure
REQ-025 Arbiter state enum and source-index type SHALL live in a new shared package, codeword_arbiter_pkg; CW_BYTES comes from interleaver_pkg.
REQ-026 The round-robin grant function SHALL be a sub-module, rr_grant2 (two request inputs, last-served input, one-hot grant).

Verification
REQ-027 Source 0 alone sends one N-byte codeword, m_axis_ready=1: all N bytes are output in order with m_axis_src=0; sop on byte 0; last on byte N-1; zero errors.
REQ-028 Both sources present sop in the same cycle after reset: source 0 codeword completes fully, then source 1; no interleaving of bytes.
REQ-029 Source 1 sends two back-to-back codewords while source 0 is pending: order is 1, 0, 1.
REQ-030 Source 0 asserts last at byte 9: len_err pulses once, the arbiter returns to IDLE, and the next codeword is accepted normally.
REQ-031 While idle, source 1 presents 3 bytes without sop: 3 desync_err pulses, nothing is output, then the sop codeword passes.
REQ-032 Run 500 codewords per source with random valid and ready gaps into byte_interleaver: the output is checked against golden vectors; fair alternation under contention.
